// File: rtl/bcd_div_sequencer.sv
// Binary-to-BCD converter that time-multiplexes one external divide-by-10 unit across NDIG digits.
// Latency: per digit one divider request phase plus one release phase; no input backpressure (start is ignored while busy).
module bcd_div_sequencer #(
    parameter int NDIG      = 6,
    parameter int TIMEOUT   = 64,
    parameter int SKIP_ZERO = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         A,
    output logic [4*NDIG-1:0]   hex,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                err,
    output logic                div_start,
    output logic [31:0]         div_dividend,
    output logic [31:0]         div_divisor,
    input  logic [31:0]         div_quotient,
    input  logic [31:0]         div_remainder,
    input  logic                div_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DIV    = 3'd1;
    localparam logic [2:0] S_CLR    = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_ABORT  = 3'd4;

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

    logic [2:0]         state_q,   state_d;
    logic [31:0]        operand_q, operand_d;
    logic [IW-1:0]      idx_q,     idx_d;
    logic [TW-1:0]      tcnt_q,    tcnt_d;
    logic [4*NDIG-1:0]  shadow_q,  shadow_d;
    logic [4*NDIG-1:0]  hex_q,     hex_d;
    logic               ovf_q,     ovf_d;
    logic               err_q,     err_d;
    logic               skip;

    // Once the running quotient hits zero, the remaining digits are already zero in the shadow.
    assign skip = (SKIP_ZERO != 0) && (operand_q == 32'd0);

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        idx_d     = idx_q;
        tcnt_d    = tcnt_q;
        shadow_d  = shadow_q;
        hex_d     = hex_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    operand_d = A;
                    idx_d     = '0;
                    tcnt_d    = '0;
                    err_d     = 1'b0;
                    shadow_d  = '0;
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                if (skip) begin
                    state_d = S_FINISH;
                end else if (div_done) begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (idx_q == IW'(i)) begin
                            shadow_d[4*i +: 4] = div_remainder[3:0];
                        end
                    end
                    operand_d = div_quotient;
                    tcnt_d    = '0;
                    if (div_remainder > 32'd9) begin
                        err_d   = 1'b1;
                        state_d = S_ABORT;
                    end else begin
                        state_d = S_CLR;
                    end
                end else if (tcnt_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_CLR: begin
                // Waiting for done to fall keeps a level-style divider from counting one result twice.
                if (!div_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        tcnt_d  = '0;
                        state_d = S_DIV;
                    end
                end else if (tcnt_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_FINISH: begin
                hex_d   = shadow_q;
                ovf_d   = (operand_q != 32'd0);
                state_d = S_IDLE;
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            operand_q <= '0;
            idx_q     <= '0;
            tcnt_q    <= '0;
            shadow_q  <= '0;
            hex_q     <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            shadow_q  <= shadow_d;
            hex_q     <= hex_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    assign hex          = hex_q;
    assign overflow     = ovf_q;
    assign err          = err_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FINISH) || (state_q == S_ABORT);
    assign div_start    = (state_q == S_DIV) && !skip;
    assign div_dividend = operand_q;
    assign div_divisor  = 32'd10;

endmodule

// File: tb/tb_bcd_div_sequencer.sv
// Bench for bcd_div_sequencer: vector table, randomized conversions against an arithmetic model,
// and hand-written timeout / bad-remainder / restart / reset sequences, all using a behavioural divider.
module tb_bcd_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [23:0] hex;
    logic        busy, done, overflow, err;
    logic        div_start;
    logic [31:0] div_dividend, div_divisor;
    logic [31:0] div_quotient, div_remainder;
    logic        div_done;

    int tests = 0;
    int fails = 0;

    // divider model controls: mode 0 = normal, 1 = never finishes, 2 = remainder 12
    int lat   = 32;
    int mode  = 0;
    bit pulse = 1'b0;
    int dcnt;

    int done_tot  = 0;
    int rise_tot  = 0;
    int stab_bad  = 0;
    logic        ds_prev  = 1'b0;
    logic [31:0] dvd_prev = '0;

    bcd_div_sequencer #(.NDIG(6), .TIMEOUT(64), .SKIP_ZERO(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .A             (A),
        .hex           (hex),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .err           (err),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_done      (div_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_done      <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
            dcnt          <= 0;
        end else if (!div_start) begin
            div_done <= 1'b0;
            dcnt     <= 0;
        end else if (div_done) begin
            if (pulse) div_done <= 1'b0;
        end else if (mode != 1) begin
            if (dcnt >= lat) begin
                div_done      <= 1'b1;
                div_quotient  <= div_dividend / 32'd10;
                div_remainder <= (mode == 2) ? 32'd12 : (div_dividend % 32'd10);
                dcnt          <= 0;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_tot++;
        if (div_start && !ds_prev) rise_tot++;
        if (ds_prev && div_start && (div_dividend != dvd_prev)) stab_bad++;
        ds_prev  = div_start;
        dvd_prev = div_dividend;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] ref_hex(input longint unsigned a);
        logic [23:0] r;
        longint unsigned v;
        r = '0;
        v = a;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int ref_divs(input longint unsigned a);
        longint unsigned v;
        int n;
        v = a;
        n = 0;
        while (v != 0 && n < 6) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    task automatic do_conv(input logic [31:0] a, output int cyc);
        @(negedge clk);
        A     = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("busy_at_done", {63'd0, busy}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [23:0] hex;
        logic        ovf;
        int          divs;
        int          cyc;
    } vec_t;

    vec_t tab[11];

    initial begin
        int cyc, bd, br;
        logic [31:0] ra;

        tab[0]  = '{32'd123456,     24'h123456, 1'b0, 6, 0};
        tab[1]  = '{32'd1234567,    24'h234567, 1'b1, 6, 0};
        tab[2]  = '{32'd0,          24'h000000, 1'b0, 0, 1};
        tab[3]  = '{32'd42,         24'h000042, 1'b0, 2, 0};
        tab[4]  = '{32'd999999,     24'h999999, 1'b0, 6, 0};
        tab[5]  = '{32'd1000000,    24'h000000, 1'b1, 6, 0};
        tab[6]  = '{32'hFFFFFFFF,   24'h967295, 1'b1, 6, 0};
        tab[7]  = '{32'd100,        24'h000100, 1'b0, 3, 0};
        tab[8]  = '{32'd7,          24'h000007, 1'b0, 1, 0};
        tab[9]  = '{32'd10,         24'h000010, 1'b0, 2, 0};
        tab[10] = '{32'd100000,     24'h100000, 1'b0, 6, 0};

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hex", {40'd0, hex}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_div_start", {63'd0, div_start}, 64'd0);
        chk("divisor", {32'd0, div_divisor}, 64'd10);
        @(negedge clk);
        rst = 1'b0;

        // table: slow level-style divider
        lat = 32; pulse = 1'b0; mode = 0;
        for (int i = 0; i < 11; i++) begin
            bd = done_tot;
            br = rise_tot;
            do_conv(tab[i].a, cyc);
            chk("tab_hex", {40'd0, hex}, {40'd0, tab[i].hex});
            chk("tab_ovf", {63'd0, overflow}, {63'd0, tab[i].ovf});
            chk("tab_err", {63'd0, err}, 64'd0);
            chk("tab_divs", 64'(rise_tot - br), 64'(tab[i].divs));
            chk("tab_done_pulses", 64'(done_tot - bd), 64'd1);
            if (tab[i].cyc != 0) chk("tab_latency", 64'(cyc), 64'(tab[i].cyc));
        end

        // randomized conversions with varying divider timing and done style
        for (int i = 0; i < 12; i++) begin
            lat   = $urandom_range(0, 4);
            pulse = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       ra = $urandom;
                1:       ra = $urandom_range(0, 999999);
                default: ra = $urandom_range(0, 999);
            endcase
            br = rise_tot;
            do_conv(ra, cyc);
            chk("rnd_hex", {40'd0, hex}, {40'd0, ref_hex(longint'(ra))});
            chk("rnd_ovf", {63'd0, overflow}, (ra >= 32'd1000000) ? 64'd1 : 64'd0);
            chk("rnd_err", {63'd0, err}, 64'd0);
            chk("rnd_divs", 64'(rise_tot - br), 64'(ref_divs(longint'(ra))));
        end

        // timeout: divider never answers
        lat = 2; pulse = 1'b0; mode = 0;
        do_conv(32'd99, cyc);
        chk("pre_to_hex", {40'd0, hex}, 64'h99);
        mode = 1;
        bd = done_tot;
        do_conv(32'd5, cyc);
        chk("to_latency", 64'(cyc), 64'd64);
        chk("to_err", {63'd0, err}, 64'd1);
        chk("to_hex", {40'd0, hex}, 64'h99);
        chk("to_done_pulses", 64'(done_tot - bd), 64'd1);

        // divider returns an illegal remainder
        mode = 2;
        do_conv(32'd321, cyc);
        chk("badrem_err", {63'd0, err}, 64'd1);
        chk("badrem_hex", {40'd0, hex}, 64'h99);
        mode = 0;
        do_conv(32'd8, cyc);
        chk("err_cleared", {63'd0, err}, 64'd0);
        chk("after_err_hex", {40'd0, hex}, 64'h8);

        // second start mid-conversion is ignored
        lat = 32;
        bd = done_tot;
        @(negedge clk);
        A = 32'd555111; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        A = 32'd777; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = '0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("restart_hex", {40'd0, hex}, 64'h555111);
        chk("restart_done_pulses", 64'(done_tot - bd), 64'd1);

        // reset during the third digit
        lat = 3; pulse = 1'b0;
        br = rise_tot;
        @(negedge clk);
        A = 32'd654321; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while ((rise_tot - br) < 3 && cyc < 500) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        chk("reached_digit3", ((rise_tot - br) >= 3) ? 64'd1 : 64'd0, 64'd1);
        bd = done_tot;
        rst = 1'b1;
        #1;
        chk("midrst_hex", {40'd0, hex}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_div_start", {63'd0, div_start}, 64'd0);
        chk("midrst_ovf", {63'd0, overflow}, 64'd0);
        chk("midrst_err", {63'd0, err}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_done", 64'(done_tot - bd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_conv(32'd31415, cyc);
        chk("post_rst_hex", {40'd0, hex}, 64'h031415);
        chk("post_rst_err", {63'd0, err}, 64'd0);

        chk("dividend_stable", 64'(stab_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_div_sequencer.md
Name: bcd_div_sequencer

Overview:
- Converts a 32-bit binary value to NDIG decimal digits using ONE shared `_32bit_DIV` divide-by-10 unit, time-multiplexed across digits.
- Replaces a six-instance divider chain, trading latency for area.
- Sits between the measurement/counter logic (value source) and the 7-segment digit drivers.
- Owns the divider handshake, the digit shadow registers, timeout supervision and the overflow flag.

Parameters:
- NDIG, 6, number of decimal digits produced (1..9).
- TIMEOUT, 64, max cycles spent waiting in either divider handshake phase before aborting (>=2).
- SKIP_ZERO, 1, when 1 the remaining digits are filled with 0 once the running quotient is 0, with no further divides.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  32  binary value; captured on the accepted start.
- hex  out  4*NDIG  BCD digits; hex[3:0] is the units digit. Registered; updated only on successful completion.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses (inclusive).
- done  out  1  one-cycle completion pulse (success or abort).
- overflow  out  1  A >= 10^NDIG on the last successful conversion.
- err  out  1  last conversion aborted (timeout or remainder > 9); sticky until the next accepted start.
- div_start  out  1  divider request; level, held high until div_done is seen.
- div_dividend  out  32  operand register, driven to the divider.
- div_divisor  out  32  constant 10.
- div_quotient  in  32  divider quotient.
- div_remainder  in  32  divider remainder.
- div_done  in  1  divider finish flag; may be a pulse or a level.

Behaviour:
- Reset (async, immediate): state=IDLE; hex=0, busy=0, done=0, overflow=0, err=0, div_start=0; operand=0, idx=0, tcnt=0, shadow=0.
- IDLE:
  - start=1 at an edge: operand<=A, idx<=0, tcnt<=0, err<=0, shadow<=0, go DIV.
  - start while not IDLE is ignored.
- DIV: busy=1, div_start=1.
  - On entry with SKIP_ZERO=1 and operand==0: div_start stays 0, remaining shadow digits stay 0, go FINISH.
  - On an edge with div_done=1:
    - shadow[idx] <= div_remainder[3:0].
    - operand <= div_quotient.
    - tcnt <= 0.
    - go CLR.
    - If div_remainder > 9: err<=1, go ABORT instead.
  - Otherwise tcnt++. When tcnt reaches TIMEOUT-1 with div_done still 0: err<=1, go ABORT.
- CLR: div_start=0.
  - Wait for div_done=0. Then:
    - if idx==NDIG-1, go FINISH;
    - else idx++, tcnt<=0, go DIV.
  - Timeout rule is identical to DIV.
  - This two-phase handshake guarantees a level-style div_done never double-counts a digit.
- FINISH (1 cycle):
  - hex <= shadow.
  - overflow <= (operand != 0) when not skipped, else 0.
  - done=1, busy=1.
  - Next state IDLE.
- ABORT (1 cycle):
  - done=1, div_start=0.
  - hex and overflow keep their previous values.
  - Next state IDLE.
- Latency (start edge to done): 1 + sum over digits of (Di + Ci) + 1 cycles.
  - Di = cycles with div_start high, including the done cycle; Ci = cycles in CLR.
  - Minimum per digit is 2.
- Dividend is stable while div_start is high; it changes only on the div_done edge.
- div_divisor is the constant 32'd10, never changed.
- Reset mid-operation: div_start drops asynchronously, no done pulse, and hex returns to 0.

Test Plan:
- Divider model with 33-cycle latency and level done. A=123456, NDIG=6 -> hex=0x123456, overflow=0, err=0, exactly one done pulse, 6 div_start rising edges.
- A=1234567 -> hex=0x234567, overflow=1, err=0.
- A=0, SKIP_ZERO=1 -> div_start never asserted, done 2 cycles after start, hex=0. A=42 -> exactly 2 divides, hex=0x000042.
- First convert A=99, then a divider that never asserts div_done, TIMEOUT=64 -> err=1 and done exactly 64 cycles after entering DIV, hex stays 0x000099.
- Second start pulse mid-conversion is ignored (result matches the first A). Assert rst during digit 3 -> all outputs 0 in the same cycle, next start converts correctly.
- Divider returns remainder 12 -> err=1, done pulse, hex unchanged.
